// File: rtl/spike_time_encoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_time_encoder
// Description : Input stage for temporal (GRL) neuron columns. Buffers one
//               spike-time vector ahead through a valid/ready slot, replays
//               the active vector over one gamma cycle as 1->0 line edges,
//               then raises a clear window so downstream state is reset.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_time_encoder #(
    parameter int NUM_INPUTS = 16,
    parameter int TIME_WIDTH = 3,
    parameter int GAMMA_LEN  = 8,
    parameter int CLEAR_LEN  = 1,
    localparam int CW        = $clog2(GAMMA_LEN)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_INPUTS-1:0][TIME_WIDTH-1:0]  in_times,
    output logic [NUM_INPUTS-1:0]                  spikes,
    output logic                                   gamma_clear,
    output logic                                   gamma_start,
    output logic [CW-1:0]                          gamma_cnt,
    output logic                                   busy
);

    // Width of the clear-window counter; at least one bit even for a 1-cycle window.
    localparam int CLW  = (CLEAR_LEN > 1) ? $clog2(CLEAR_LEN) : 1;
    // Spike-time vs. cycle comparison is done at the wider of the two widths.
    localparam int CMPW = (TIME_WIDTH > CW) ? TIME_WIDTH : CW;

    localparam logic [CW-1:0]  c_LAST_CNT = CW'(GAMMA_LEN - 1);
    localparam logic [CLW-1:0] c_CLR_LAST = CLW'(CLEAR_LEN - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;

    logic [1:0]                             r_state;
    logic [1:0]                             w_state_nxt;
    logic                                   r_pend_full;
    logic [NUM_INPUTS-1:0][TIME_WIDTH-1:0]  r_pend;
    logic [NUM_INPUTS-1:0][TIME_WIDTH-1:0]  r_active;
    logic [CW-1:0]                          r_cnt;
    logic [CLW-1:0]                         r_clr_cnt;
    logic                                   w_load;
    logic                                   w_accept;
    logic                                   w_run;
    logic                                   w_run_last;
    logic                                   w_clr_last;
    logic [CMPW-1:0]                        w_cnt_ext;

    assign w_run      = (r_state == c_ST_RUN);
    assign w_run_last = (r_cnt == c_LAST_CNT);
    assign w_clr_last = (r_clr_cnt == c_CLR_LAST);
    // The pending slot is never overwritten: data is only taken while it is empty.
    assign w_accept   = in_valid & ~r_pend_full;

    // Next-state decode; w_load marks the cycle the pending vector moves to active.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_pend_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_run_last) begin
                    w_state_nxt = c_ST_CLEAR;
                end
            end
            c_ST_CLEAR: begin
                if (w_clr_last) begin
                    if (r_pend_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gamma cycle counter and clear-window counter; both sit at zero outside their phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_clr_cnt <= '0;
        end else begin
            if (w_run && !w_run_last) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == c_ST_CLEAR) && !w_clr_last) begin
                r_clr_cnt <= r_clr_cnt + CLW'(1);
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    // Pending slot capture and transfer of the pending vector into the active register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend      <= '0;
            r_active    <= '0;
        end else begin
            if (w_accept) begin
                r_pend      <= in_times;
                r_pend_full <= 1'b1;
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end
            if (w_load) begin
                r_active <= r_pend;
            end
        end
    end

    assign w_cnt_ext = CMPW'(r_cnt);

    // Each line drops once the gamma count reaches its spike time and stays low
    // until RUN ends; times at or beyond GAMMA_LEN are never reached.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_spike
        logic [CMPW-1:0] w_time_ext;
        assign w_time_ext  = CMPW'(r_active[gi]);
        assign spikes[gi]  = ~(w_run & (w_time_ext <= w_cnt_ext));
    end

    assign in_ready    = ~r_pend_full;
    assign busy        = (r_state != c_ST_IDLE);
    assign gamma_clear = (r_state == c_ST_CLEAR);
    assign gamma_start = w_run & (r_cnt == '0);
    assign gamma_cnt   = w_run ? r_cnt : '0;

endmodule
`default_nettype wire
